rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 42 ++++
 rtl/rom_loader_if.sv | 28 ++
 rtl/rom_region_dec.sv | 44 ++++
 rtl/rom_loader.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared constants and types for the ROM loader: region map, FSM states, download indices.
// The optional DIP-switch bank is enabled by defining ROM_LOADER_DIP_EN.
package rom_loader_pkg;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;

  localparam logic [26:0] MAIN_BASE = 27'h0000000;
  localparam logic [26:0] MAIN_LEN  = 27'h0010000;
  localparam logic [26:0] SND_BASE  = 27'h0010000;
  localparam logic [26:0] SND_LEN   = 27'h0008000;
  localparam logic [26:0] CHAR_BASE = 27'h0018000;
  localparam logic [26:0] CHAR_LEN  = 27'h0002000;
  localparam logic [26:0] TILE_BASE = 27'h001A000;
  localparam logic [26:0] TILE_LEN  = 27'h0018000;
  localparam logic [26:0] SPR_BASE  = 27'h0032000;
  localparam logic [26:0] SPR_LEN   = 27'h0018000;
  localparam logic [26:0] PROM_BASE = 27'h004A000;
  localparam logic [26:0] PROM_LEN  = 27'h0000400;

  typedef enum logic [2:0] {
    RGN_MAIN   = 3'd0,
    RGN_SOUND  = 3'd1,
    RGN_CHAR   = 3'd2,
    RGN_TILE   = 3'd3,
    RGN_SPRITE = 3'd4,
    RGN_PROM   = 3'd5
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_e;

  function automatic logic in_range(input logic [26:0] a,
                                    input logic [26:0] base,
                                    input logic [26:0] len);
    return (a >= base) && (a < (base + len));
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// HPS download bus plus ROM write port and status outputs of the ROM loader.
// master = download source / testbench side, slave = rom_loader.
interface rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        rom_we;
  logic [2:0]  rom_sel;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic        dn_done;
  logic        overrun;
  logic [7:0]  dsw;
  logic [7:0]  p3;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, rom_we, rom_sel, rom_addr, rom_data, dn_done, overrun, dsw, p3
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, rom_we, rom_sel, rom_addr, rom_data, dn_done, overrun, dsw, p3
  );
endinterface

// File: rtl/rom_region_dec.sv
// Combinational byte-address decoder: address -> {valid, region, offset within region}.
// Addresses past the end of the PROM region decode as invalid.
module rom_region_dec
  import rom_loader_pkg::*;
(
  input  logic [26:0] byte_addr_i,
  output logic        valid_o,
  output region_e     sel_o,
  output logic [17:0] offs_o
);

  logic [26:0] base;

  // Half-open range match against each region in address order.
  always_comb begin
    valid_o = 1'b1;
    sel_o   = RGN_MAIN;
    base    = MAIN_BASE;
    if (in_range(byte_addr_i, MAIN_BASE, MAIN_LEN)) begin
      sel_o = RGN_MAIN;
      base  = MAIN_BASE;
    end else if (in_range(byte_addr_i, SND_BASE, SND_LEN)) begin
      sel_o = RGN_SOUND;
      base  = SND_BASE;
    end else if (in_range(byte_addr_i, CHAR_BASE, CHAR_LEN)) begin
      sel_o = RGN_CHAR;
      base  = CHAR_BASE;
    end else if (in_range(byte_addr_i, TILE_BASE, TILE_LEN)) begin
      sel_o = RGN_TILE;
      base  = TILE_BASE;
    end else if (in_range(byte_addr_i, SPR_BASE, SPR_LEN)) begin
      sel_o = RGN_SPRITE;
      base  = SPR_BASE;
    end else if (in_range(byte_addr_i, PROM_BASE, PROM_LEN)) begin
      sel_o = RGN_PROM;
      base  = PROM_BASE;
    end else begin
      valid_o = 1'b0;
    end
  end

  assign offs_o = 18'(byte_addr_i - base);

endmodule

// File: rtl/rom_loader.sv
// Splits 16-bit HPS download words into two byte writes routed to ROM regions.
// Defining ROM_LOADER_DIP_EN adds an 8-byte DIP bank loaded through index 254.
module rom_loader
  import rom_loader_pkg::*;
(
  input  logic         clk_sys,
  input  logic         reset_n,
  rom_loader_if.slave  bus
);

  state_e      state_q;
  logic [26:0] addr_q;
  logic [7:0]  hi_byte_q;
  logic        dl_q;
  logic        done_pend_q;
  logic        wait_q;
  logic        we_q;
  logic        done_q;
  logic        overrun_q;
  logic [2:0]  sel_q;
  logic [17:0] raddr_q;
  logic [7:0]  rdata_q;

  logic        lo_valid_d, hi_valid_d;
  region_e     lo_sel_d, hi_sel_d;
  logic [17:0] lo_offs_d, hi_offs_d;
  logic [26:0] hi_addr_d;
  logic        accept_d;
  logic        dl_fall_d;

  assign hi_addr_d = addr_q + 27'd1;
  assign accept_d  = (state_q == ST_IDLE) && bus.ioctl_download && bus.ioctl_wr &&
                     (bus.ioctl_index == IDX_ROM);
  assign dl_fall_d = dl_q && !bus.ioctl_download && (bus.ioctl_index == IDX_ROM);

  // Low byte decodes straight from the bus so its write can be registered on acceptance.
  rom_region_dec u_dec_lo (
    .byte_addr_i (bus.ioctl_addr),
    .valid_o     (lo_valid_d),
    .sel_o       (lo_sel_d),
    .offs_o      (lo_offs_d)
  );

  rom_region_dec u_dec_hi (
    .byte_addr_i (hi_addr_d),
    .valid_o     (hi_valid_d),
    .sel_o       (hi_sel_d),
    .offs_o      (hi_offs_d)
  );

  // Word sequencer with registered write port, stall, completion and overrun flags.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= 27'd0;
      hi_byte_q   <= 8'd0;
      dl_q        <= 1'b0;
      done_pend_q <= 1'b0;
      wait_q      <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      sel_q       <= 3'd0;
      raddr_q     <= 18'd0;
      rdata_q     <= 8'd0;
    end else begin
      dl_q   <= bus.ioctl_download;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (bus.ioctl_wr && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      // A falling download edge seen in LO is held until the HI cycle, so the pulse follows HI.
      if (dl_fall_d || done_pend_q) begin
        if (state_q == ST_LO) begin
          done_pend_q <= 1'b1;
        end else begin
          done_q      <= 1'b1;
          done_pend_q <= 1'b0;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            state_q   <= ST_LO;
            addr_q    <= bus.ioctl_addr;
            hi_byte_q <= bus.ioctl_dout[15:8];
            wait_q    <= 1'b1;
            if (lo_valid_d) begin
              we_q    <= 1'b1;
              sel_q   <= lo_sel_d;
              raddr_q <= lo_offs_d;
              rdata_q <= bus.ioctl_dout[7:0];
            end
          end
        end
        ST_LO: begin
          state_q <= ST_HI;
          if (hi_valid_d) begin
            we_q    <= 1'b1;
            sel_q   <= hi_sel_d;
            raddr_q <= hi_offs_d;
            rdata_q <= hi_byte_q;
          end
        end
        ST_HI: begin
          state_q <= ST_IDLE;
          wait_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          wait_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.rom_we     = we_q;
  assign bus.rom_sel    = sel_q;
  assign bus.rom_addr   = raddr_q;
  assign bus.rom_data   = rdata_q;
  assign bus.dn_done    = done_q;
  assign bus.overrun    = overrun_q;

`ifdef ROM_LOADER_DIP_EN
  logic [7:0] bank_q [8];

  // DIP bytes bypass the word sequencer and land one cycle after the strobe.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        bank_q[i] <= 8'hFF;
      end
    end else if (bus.ioctl_download && bus.ioctl_wr && (bus.ioctl_index == IDX_DIP) &&
                 (bus.ioctl_addr[24:3] == 22'd0)) begin
      bank_q[bus.ioctl_addr[2:0]] <= bus.ioctl_dout[7:0];
    end
  end

  assign bus.dsw = bank_q[0];
  assign bus.p3  = bank_q[1];
`else
  assign bus.dsw = 8'hFF;
  assign bus.p3  = 8'hFF;
`endif

endmodule
